// File: rtl/am29_pkg.sv
// Shared definitions for the Am2901 self-test sequencer: instruction field
// codes, sequencer state encoding and observed-word bit positions.
package am29_pkg;

    // Am2901 source operand codes (I[2:0])
    localparam logic [2:0] SRC_AQ = 3'b000;
    localparam logic [2:0] SRC_DQ = 3'b110;
    localparam logic [2:0] SRC_DZ = 3'b111;

    // Am2901 function code (I[5:3])
    localparam logic [2:0] FN_ADD = 3'b000;

    // Am2901 destination codes (I[8:6])
    localparam logic [2:0] DST_QREG = 3'b000;
    localparam logic [2:0] DST_NOP  = 3'b001;

    localparam int VEC_W = 12;
    localparam int OBS_W = 12;

    // Bit positions inside the observed word {2'b00, g_n, p_n, cout, ovr, f3, zf, y[3:0]}
    localparam int OBS_Y_LSB = 0;
    localparam int OBS_ZF    = 4;
    localparam int OBS_F3    = 5;
    localparam int OBS_OVR   = 6;
    localparam int OBS_COUT  = 7;
    localparam int OBS_P_N   = 8;
    localparam int OBS_G_N   = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_OPER = 2'd2,
        ST_DONE = 2'd3
    } bist_state_e;

    // Assemble a 9-bit Am2901 instruction word from its three fields.
    function automatic logic [8:0] alu_instr(input logic [2:0] dst,
                                             input logic [2:0] fn,
                                             input logic [2:0] src);
        return {dst, fn, src};
    endfunction

endpackage

// File: rtl/am29_bist_cmp.sv
// Response comparator: packs the slice outputs into the observed word and
// compares it with the reference ROM word. Purely combinational.
module am29_bist_cmp
    import am29_pkg::*;
(
    input  logic [3:0]       alu_y,
    input  logic             alu_zf,
    input  logic             alu_f3,
    input  logic             alu_ovr,
    input  logic             alu_cout,
    input  logic             alu_p_n,
    input  logic             alu_g_n,
    input  logic [OBS_W-1:0] rom_data,
    output logic [OBS_W-1:0] xor_word,
    output logic             mismatch
);

    logic [OBS_W-1:0] obs;

    // Pack the observed word and flag any bit that differs from the reference.
    always_comb begin
        obs                  = '0;
        obs[OBS_Y_LSB +: 4]  = alu_y;
        obs[OBS_ZF]          = alu_zf;
        obs[OBS_F3]          = alu_f3;
        obs[OBS_OVR]         = alu_ovr;
        obs[OBS_COUT]        = alu_cout;
        obs[OBS_P_N]         = alu_p_n;
        obs[OBS_G_N]         = alu_g_n;
        xor_word             = obs ^ rom_data;
        mismatch             = |xor_word;
    end

endmodule

// File: rtl/am29_bist.sv
// Am2901 slice self-test sequencer. Each vector takes two clocks: LOAD puts
// vec[7:4] into Q, OPER applies vec[11:9] as the ALU function on (D=vec[3:0], Q)
// with carry vec[8] and compares the flags/Y against a 1-latency reference ROM.
// Optional feature macro AM29_BIST_CONT_EN: keep running past mismatches and
// count them in err_cnt (saturating); otherwise halt at the first mismatch.
module am29_bist
    import am29_pkg::*;
#(
    parameter int VEC_CNT = 4095,
    parameter int ROM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [8:0]       alu_i,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [3:0]       alu_d,
    output logic             alu_cin,
    output logic             alu_oe_n,
    input  logic [3:0]       alu_y,
    input  logic             alu_zf,
    input  logic             alu_f3,
    input  logic             alu_ovr,
    input  logic             alu_cout,
    input  logic             alu_p_n,
    input  logic             alu_g_n,
    output logic [VEC_W-1:0] rom_addr,
    input  logic [OBS_W-1:0] rom_data,
    output logic [VEC_W-1:0] fail_vec,
    output logic [OBS_W-1:0] fail_xor,
    output logic [VEC_W-1:0] err_cnt
);

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(VEC_CNT - 1);
    // Only a one-clock ROM lines up with the OPER cycle; any other latency
    // makes every vector fail so a misbuilt board cannot report a false pass.
    localparam bit LAT_OK = (ROM_LAT == 1);

    bist_state_e      state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic             pass_q, pass_d;
    logic             fail_seen_q, fail_seen_d;
    logic [VEC_W-1:0] fail_vec_q, fail_vec_d;
    logic [OBS_W-1:0] fail_xor_q, fail_xor_d;
`ifdef AM29_BIST_CONT_EN
    logic [VEC_W-1:0] err_cnt_q, err_cnt_d;
`endif

    logic [OBS_W-1:0] cmp_xor;
    logic             cmp_mismatch;
    logic             mismatch;

    am29_bist_cmp u_cmp (
        .alu_y    (alu_y),
        .alu_zf   (alu_zf),
        .alu_f3   (alu_f3),
        .alu_ovr  (alu_ovr),
        .alu_cout (alu_cout),
        .alu_p_n  (alu_p_n),
        .alu_g_n  (alu_g_n),
        .rom_data (rom_data),
        .xor_word (cmp_xor),
        .mismatch (cmp_mismatch)
    );

    assign mismatch = cmp_mismatch || !LAT_OK;

    // Next-state, result capture and slice drive for the LOAD/OPER sequence.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        vec_d       = vec_q;
        pass_d      = pass_q;
        fail_seen_d = fail_seen_q;
        fail_vec_d  = fail_vec_q;
        fail_xor_d  = fail_xor_q;
`ifdef AM29_BIST_CONT_EN
        err_cnt_d   = err_cnt_q;
`endif
        alu_i       = alu_instr(DST_NOP, FN_ADD, SRC_AQ);
        alu_d       = 4'h0;
        alu_cin     = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    vec_d       = '0;
                    pass_d      = 1'b0;
                    fail_seen_d = 1'b0;
                    fail_vec_d  = '0;
                    fail_xor_d  = '0;
`ifdef AM29_BIST_CONT_EN
                    err_cnt_d   = '0;
`endif
                end
            end

            ST_LOAD: begin
                // Q <= D + 0 at the closing edge, seeding the S operand.
                alu_i   = alu_instr(DST_QREG, FN_ADD, SRC_DZ);
                alu_d   = vec_q[7:4];
                state_d = ST_OPER;
            end

            ST_OPER: begin
                alu_i   = alu_instr(DST_QREG, vec_q[11:9], SRC_DQ);
                alu_d   = vec_q[3:0];
                alu_cin = vec_q[8];

                if (mismatch && !fail_seen_q) begin
                    fail_seen_d = 1'b1;
                    fail_vec_d  = vec_q;
                    fail_xor_d  = cmp_xor;
                end

`ifdef AM29_BIST_CONT_EN
                if (mismatch && (err_cnt_q != {VEC_W{1'b1}})) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
                if (vec_q == LAST_VEC) begin
                    state_d = ST_DONE;
                    pass_d  = (err_cnt_d == '0);
                end else begin
                    vec_d   = vec_q + 1'b1;
                    state_d = ST_LOAD;
                end
`else
                if (mismatch) begin
                    state_d = ST_DONE;
                    pass_d  = 1'b0;
                end else if (vec_q == LAST_VEC) begin
                    state_d = ST_DONE;
                    pass_d  = 1'b1;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    state_d = ST_LOAD;
                end
`endif
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers; reset aborts a run and clears all results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vec_q       <= '0;
            pass_q      <= 1'b0;
            fail_seen_q <= 1'b0;
            fail_vec_q  <= '0;
            fail_xor_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            vec_q       <= vec_d;
            pass_q      <= pass_d;
            fail_seen_q <= fail_seen_d;
            fail_vec_q  <= fail_vec_d;
            fail_xor_q  <= fail_xor_d;
        end
    end

`ifdef AM29_BIST_CONT_EN
    // Saturating mismatch counter for continue-on-error runs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end
    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

    assign busy     = (state_q == ST_LOAD) || (state_q == ST_OPER);
    assign done     = (state_q == ST_DONE);
    assign pass     = pass_q;
    assign rom_addr = vec_q;
    assign fail_vec = fail_vec_q;
    assign fail_xor = fail_xor_q;
    assign alu_a    = 4'h0;
    assign alu_b    = 4'h0;
    assign alu_oe_n = 1'b0;

endmodule

// File: tb/tb_am29_bist.sv
// Self-checking bench for am29_bist. The bench plays both the Am2901 slice
// (behavioural ALU driven by the sequencer outputs) and the reference ROM
// (golden responses with optional bit flips). Expected run results come from
// a model over the set of corrupted ROM words and go into a scoreboard that a
// monitor checks when done rises; a second monitor checks the slice drive.
module tb_am29_bist;
    import am29_pkg::*;

    localparam int VEC_CNT     = 4095;
    localparam int RUN_TIMEOUT = 2 * 4096 + 64;
`ifdef AM29_BIST_CONT_EN
    localparam bit CONT_MODE = 1'b1;
`else
    localparam bit CONT_MODE = 1'b0;
`endif

    typedef struct {
        int          done_cyc;
        logic        pass;
        logic [11:0] fail_vec;
        logic [11:0] fail_xor;
        logic [11:0] err_cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, pass;
    logic [8:0]  alu_i;
    logic [3:0]  alu_a, alu_b, alu_d;
    logic        alu_cin, alu_oe_n;
    logic [3:0]  alu_y;
    logic        alu_zf, alu_f3, alu_ovr, alu_cout, alu_p_n, alu_g_n;
    logic [11:0] rom_addr, rom_data, fail_vec, fail_xor, err_cnt;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    exp_t        sb_q[$];
    logic [11:0] rom  [4096];
    logic [11:0] flip [4096];
    logic [3:0]  q_reg = 4'h0;

    bit          run_active = 1'b0;
    int          run_base   = 0;
    int          run_len    = 0;
    logic        done_prev  = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    am29_bist #(.VEC_CNT(VEC_CNT), .ROM_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .alu_i(alu_i), .alu_a(alu_a), .alu_b(alu_b), .alu_d(alu_d), .alu_cin(alu_cin),
        .alu_oe_n(alu_oe_n), .alu_y(alu_y), .alu_zf(alu_zf), .alu_f3(alu_f3),
        .alu_ovr(alu_ovr), .alu_cout(alu_cout), .alu_p_n(alu_p_n), .alu_g_n(alu_g_n),
        .rom_addr(rom_addr), .rom_data(rom_data), .fail_vec(fail_vec),
        .fail_xor(fail_xor), .err_cnt(err_cnt)
    );

    // Am2901 ALU response as an observed word {2'b00,g_n,p_n,cout,ovr,f3,zf,f}.
    // Arithmetic uses textbook carry lookahead; logic functions report idle flags.
    function automatic logic [11:0] alu_eval(input logic [2:0] fn, input logic [3:0] r,
                                             input logic [3:0] s, input logic cin);
        logic [3:0] r2, s2, f, p, g;
        logic [4:0] sum, low;
        logic       cout, ovr, p_n, g_n;
        r2 = r; s2 = s; f = 4'h0;
        cout = 1'b0; ovr = 1'b0; p_n = 1'b1; g_n = 1'b1;
        case (fn)
            3'd0, 3'd1, 3'd2: begin
                if (fn == 3'd1) r2 = ~r;
                if (fn == 3'd2) s2 = ~s;
                sum  = {1'b0, r2} + {1'b0, s2} + {4'b0, cin};
                low  = {2'b0, r2[2:0]} + {2'b0, s2[2:0]} + {4'b0, cin};
                f    = sum[3:0];
                cout = sum[4];
                ovr  = low[3] ^ cout;
                p    = r2 | s2;
                g    = r2 & s2;
                p_n  = ~(&p);
                g_n  = ~(g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (&p[3:1] & g[0]));
            end
            3'd3:    f = r | s;
            3'd4:    f = r & s;
            3'd5:    f = ~r & s;
            3'd6:    f = r ^ s;
            default: f = ~(r ^ s);
        endcase
        return {2'b00, g_n, p_n, cout, ovr, f[3], (f == 4'h0), f};
    endfunction

    // Golden response for a vector: D = v[3:0] as R, Q = v[7:4] as S.
    function automatic logic [11:0] golden(input logic [11:0] v);
        return alu_eval(v[11:9], v[3:0], v[7:4], v[8]);
    endfunction

    // Behavioural slice: register file is never written, so A/B read 0.
    logic [3:0]  alu_r, alu_s;
    logic [11:0] alu_word;
    always_comb begin
        alu_r = 4'h0;
        alu_s = 4'h0;
        case (alu_i[2:0])
            3'd0:    alu_s = q_reg;
            3'd2:    alu_s = q_reg;
            3'd5:    alu_r = alu_d;
            3'd6:    begin alu_r = alu_d; alu_s = q_reg; end
            3'd7:    alu_r = alu_d;
            default: ;
        endcase
        alu_word = alu_eval(alu_i[5:3], alu_r, alu_s, alu_cin);
    end
    assign alu_y    = alu_word[3:0];
    assign alu_zf   = alu_word[4];
    assign alu_f3   = alu_word[5];
    assign alu_ovr  = alu_word[6];
    assign alu_cout = alu_word[7];
    assign alu_p_n  = alu_word[8];
    assign alu_g_n  = alu_word[9];

    always @(posedge clk) if (alu_i[8:6] == DST_QREG) q_reg <= alu_word[3:0];
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    // Slice-drive monitor and done/result scoreboard monitor.
    int          mon_d;
    logic [11:0] mon_v;
    logic [36:0] mon_exp, mon_act;
    logic [11:0] mon_obs;
    exp_t        mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            mon_d = cyc - run_base;
            if (!run_active || mon_d >= 0) begin
                mon_exp = {1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 9'h040, 4'h0, 1'b0, 12'h000};
                mon_act = {busy, done, alu_a, alu_b, alu_oe_n, alu_i, alu_d, alu_cin, 12'h000};
                if (run_active && mon_d < run_len) begin
                    mon_v = 12'(mon_d / 2);
                    if (mon_d % 2 == 0) begin
                        mon_exp = {1'b1, 1'b0, 9'h000, 9'h007, mon_v[7:4], 1'b0, mon_v};
                        mon_act[11:0] = rom_addr;
                    end else begin
                        mon_exp = {1'b1, 1'b0, 9'h000, 3'b000, mon_v[11:9], 3'b110,
                                   mon_v[3:0], mon_v[8], 12'h000};
                        mon_obs = {2'b00, alu_g_n, alu_p_n, alu_cout, alu_ovr, alu_f3, alu_zf, alu_y};
                        if (mon_v == 12'h000) check("obs_vec_000", mon_obs, 12'h310);
                        if (mon_v == 12'h1FF) check("obs_vec_1ff", mon_obs, 12'h0AF);
                    end
                end else if (run_active) begin
                    mon_exp[35] = 1'b1;
                end
                check("slice_drive", mon_act, mon_exp);
            end
            if (done && !done_prev) begin
                check("done_expected", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    check("done_cycle", cyc, mon_e.done_cyc);
                    check("pass", pass, mon_e.pass);
                    check("fail_vec", fail_vec, mon_e.fail_vec);
                    check("fail_xor", fail_xor, mon_e.fail_xor);
                    check("err_cnt", err_cnt, mon_e.err_cnt);
                end
            end
        end
        done_prev <= done;
    end

    task automatic clear_flips();
        for (int i = 0; i < 4096; i++) flip[i] = 12'h000;
    endtask

    task automatic load_rom();
        for (int i = 0; i < 4096; i++) rom[i] = golden(12'(i)) ^ flip[i];
    endtask

    // Reference model: predict the run outcome from the corrupted ROM words.
    task automatic start_run(input bit abort);
        int   first, fi, cnt, len;
        exp_t e;
        first = -1;
        cnt   = 0;
        for (int v = 0; v < VEC_CNT; v++) begin
            if (flip[v] != 12'h000) begin
                cnt++;
                if (first < 0) first = v;
            end
        end
        fi  = (first < 0) ? 0 : first;
        len = (CONT_MODE || first < 0) ? 2 * VEC_CNT : 2 * first + 2;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        e.done_cyc = cyc + 1 + len;
        e.pass     = (first < 0);
        e.fail_vec = (first < 0) ? 12'h000 : 12'(first);
        e.fail_xor = (first < 0) ? 12'h000 : flip[fi];
        e.err_cnt  = CONT_MODE ? 12'((cnt > 4095) ? 4095 : cnt) : 12'h000;
        if (!abort) sb_q.push_back(e);
        run_base   = cyc + 1;
        run_len    = len;
        run_active = 1'b1;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < RUN_TIMEOUT) begin
            @(posedge clk); #1;
            n++;
        end
        check("run_timeout_pending", sb_q.size(), 0);
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ctrl"}, {busy, done, pass, alu_i, alu_d, alu_cin, alu_a, alu_b, alu_oe_n},
              {3'b000, 9'h040, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0});
        check({tag, "_rom_addr"}, rom_addr, 12'h000);
        check({tag, "_fail_vec"}, fail_vec, 12'h000);
        check({tag, "_fail_xor"}, fail_xor, 12'h000);
        check({tag, "_err_cnt"}, err_cnt, 12'h000);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        clear_flips();
        load_rom();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Clean run with start pulses while busy (must be ignored).
        start_run(1'b0);
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(5, 40)) @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        wait_done();

        // Restart from DONE with word 5 corrupted in bit 7.
        flip[5] = 12'h080;
        load_rom();
        start_run(1'b0);
        wait_done();

        // Words 5 and 9 corrupted.
        flip[9] = 12'h021;
        load_rom();
        start_run(1'b0);
        wait_done();

        // Random corruption sets.
        for (int r = 0; r < 2; r++) begin
            clear_flips();
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                flip[$urandom_range(0, VEC_CNT - 1)] ^= 12'($urandom_range(1, 4095));
            end
            load_rom();
            start_run(1'b0);
            wait_done();
        end

        // Reset during OPER of vector 100 aborts; a new start restarts at 0.
        clear_flips();
        load_rom();
        start_run(1'b1);
        while (cyc - run_base < 201) begin
            @(posedge clk); #1;
        end
        rst        = 1'b1;
        run_active = 1'b0;
        @(negedge clk);
        check_reset_values("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        start_run(1'b0);
        wait_done();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/am29_bist.md
Name: am29_bist

Overview:
- Self-test sequencer for one Am2901 ALU slice.
- Drives the slice's control, operand and carry inputs through a two-cycle load/operate sequence for each test vector.
- Fetches the expected response from a synchronous reference ROM, compares it with the slice outputs, and reports pass/fail with the first failing vector.
- Sits beside the am2901 instance in FPGA board tops, so the ALU can be checked on silicon without a simulator.

Parameters:
- VEC_CNT, 4095: number of vectors run, indices 0..VEC_CNT-1 (max 4096).
- ROM_LAT, 1: reference ROM read latency in clocks; only 1 is supported.

Ports:
- clk  in  1  main clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle pulse; begins a run.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start.
- pass  out  1  valid when done=1; 1 = all vectors matched.
- alu_i  out  9  Am2901 I[8:0].
- alu_a  out  4  A address; constant 0.
- alu_b  out  4  B address; constant 0.
- alu_d  out  4  direct data.
- alu_cin  out  1  carry in.
- alu_oe_n  out  1  Y enable; constant 0.
- alu_y  in  4  ALU Y output.
- alu_zf, alu_f3, alu_ovr, alu_cout, alu_p_n, alu_g_n  in  1 each  ALU flag outputs.
- rom_addr  out  12  reference ROM address.
- rom_data  in  12  reference word, valid one clock after rom_addr.
- fail_vec  out  12  index of the first mismatching vector.
- fail_xor  out  12  observed XOR reference for that vector.
- err_cnt  out  12  mismatch count (only with the optional feature; otherwise 0).

Behaviour:
- Observed word: obs = {2'b00, g_n, p_n, cout, ovr, f3, zf, y[3:0]}.
- States: IDLE, LOAD, OPER, DONE.
  - IDLE/DONE: alu_i = 9'b001_000_000 (NOP destination, ADD, source AQ), alu_d = 0, alu_cin = 0.
  - start in IDLE or DONE: vec <= 0, err/fail registers cleared, go to LOAD.
  - start while busy: ignored.
- LOAD (1 clock):
  - alu_i = 9'b000_000_111 (QREG destination, ADD, source D,0), alu_d = vec[7:4], alu_cin = 0, so Q <= vec[7:4] at the clock edge.
  - rom_addr = vec.
  - Next state: OPER.
- OPER (1 clock):
  - alu_i = {3'b000, vec[11:9], 3'b110} (source D,Q), alu_d = vec[3:0], alu_cin = vec[8].
  - rom_data is valid.
  - At the closing edge, sample mismatch = (obs != rom_data) from the pre-edge combinational outputs.
  - On the first mismatch: fail_vec <= vec, fail_xor <= obs ^ rom_data.
  - Next state:
    - mismatch without feature: DONE, pass=0.
    - vec == VEC_CNT-1: DONE, pass = no mismatch seen.
    - otherwise: vec++ and LOAD.
- Latency: 2 clocks per vector; a clean run takes start + 2*VEC_CNT clocks before done rises.
- busy = state is LOAD or OPER. done = state is DONE.
- Reset values: state IDLE; busy/done/pass 0; alu_i 9'b001_000_000; alu_d 0; alu_cin 0; rom_addr 0; fail_vec 0; fail_xor 0; err_cnt 0.
- Reset mid-run aborts immediately; no partial results are kept.
- vec is 12 bits; VEC_CNT=4096 ends at 12'hFFF without wrap.
- Outputs alu_a, alu_b and alu_oe_n are tied to 0 in every state.

Optional Feature:
- Macro: AM29_BIST_CONT_EN.
- Defined:
  - A mismatch does not stop the run.
  - err_cnt increments per mismatch and saturates at 12'hFFF.
  - fail_vec/fail_xor hold the first failure only.
  - pass = (err_cnt == 0) at DONE.
- Undefined: halt at the first mismatch; err_cnt is tied to 0.

Decomposition:
- Package am29_pkg:
  - Am2901 source/function/destination codes (SRC_DZ=3'b111, SRC_DQ=3'b110, SRC_AQ=3'b000, FN_ADD=3'b000, DST_QREG=3'b000, DST_NOP=3'b001).
  - State encoding.
  - Observed-word bit positions.
- Sub-module am29_bist_cmp: packs obs, computes mismatch and the xor word; purely combinational.

Test Plan:
- start with a correct am2901 and matching ROM, VEC_CNT=4095 -> done after 8191 clocks, pass=1, fail_vec=0.
- Vector 12'h000 -> obs 12'h310; vector 12'h1FF (ADD, cin=1, D=F, Q=F) -> obs 12'h0AF; both accepted.
- ROM word 5 corrupted by flipping bit 7 -> done at vector 5, pass=0, fail_vec=12'h005, fail_xor=12'h080.
- With AM29_BIST_CONT_EN and ROM words 5 and 9 corrupted -> full run completes, err_cnt=2, fail_vec=12'h005, pass=0.
- rst asserted during OPER of vector 100 -> next cycle IDLE, busy=0, alu_i=9'b001_000_000; a new start restarts from vector 0.
- start pulsed while busy -> ignored, vec sequence unchanged; start pulsed in DONE -> rerun and done cleared.
